// File: rtl/bcd_seg_pkg.sv
// bcd_seg_pkg: shared 7-segment types, glyph constants and BCD decode function.
package bcd_seg_pkg;
  typedef logic [6:0] seg7_t;
  localparam seg7_t SEG_0    = 7'b0111111;
  localparam seg7_t SEG_1    = 7'b0000110;
  localparam seg7_t SEG_2    = 7'b1011011;
  localparam seg7_t SEG_3    = 7'b1001111;
  localparam seg7_t SEG_4    = 7'b1100110;
  localparam seg7_t SEG_5    = 7'b1101101;
  localparam seg7_t SEG_6    = 7'b1111101;
  localparam seg7_t SEG_7    = 7'b0000111;
  localparam seg7_t SEG_8    = 7'b1111111;
  localparam seg7_t SEG_9    = 7'b1101111;
  localparam seg7_t SEG_DASH = 7'b1000000;
  localparam seg7_t SEG_OFF  = 7'b0000000;

  function automatic seg7_t bcd_to_seg7(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction
endpackage

// File: rtl/bcd_seg_decode.sv
// bcd_seg_decode: combinational BCD digit to active-high segments (a..g, bit0=a).
module bcd_seg_decode
  import bcd_seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output seg7_t      seg_o
);
  assign seg_o = bcd_to_seg7(bcd_i);
endmodule

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: captures a BCD counter value and scans it onto a multiplexed 7-seg display.
// Define BCD_SEG_SCAN_LZB_EN to blank leading zero digits.
module bcd_seg_scan
  import bcd_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    clr_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    ovf_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    bad_digit
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);

  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    ovf_q, ovf_d, bad_q, bad_d, bad_any, gap;
  logic [PW-1:0]           pre_q, pre_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    dp_q, dp_d;
  logic [3:0]              dig;
  seg7_t                   seg_q, seg_d, dec;
`ifdef BCD_SEG_SCAN_LZB_EN
  logic                    lit;
`endif

  bcd_seg_decode u_dec (.bcd_i(dig), .seg_o(dec));

  // Outputs are built from next-state values so a capture or wrap shows on the same edge.
  always_comb begin
    shadow_d = load ? bcd_in : shadow_q;
    ovf_d    = load ? ovf_in : ovf_q;
    bad_any  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      bad_any = bad_any | (bcd_in[4*i+3] & (bcd_in[4*i+2] | bcd_in[4*i+1]));
    bad_d = load ? bad_any : bad_q;
    pre_d = (pre_q == PW'(SCAN_DIV - 1)) ? '0 : pre_q + 1'b1;
    idx_d = (pre_d != '0) ? idx_q : (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    dig   = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (idx_d == IW'(i)) dig = shadow_d[4*i +: 4];
`ifdef BCD_SEG_SCAN_LZB_EN
    lit = (idx_d == '0);
    for (int i = 0; i < NUM_DIGITS; i++)
      if (IW'(i) >= idx_d && shadow_d[4*i +: 4] != 4'd0) lit = 1'b1;
`endif
    gap   = (pre_d == '0);
    sel_d = gap ? '0 : NUM_DIGITS'(1) << idx_d;
`ifdef BCD_SEG_SCAN_LZB_EN
    seg_d = (gap || !lit) ? SEG_OFF : dec;
`else
    seg_d = gap ? SEG_OFF : dec;
`endif
    dp_d  = !gap && (idx_d == IW'(NUM_DIGITS - 1)) && ovf_d;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      shadow_q <= '0;
      ovf_q    <= 1'b0;
      bad_q    <= 1'b0;
      pre_q    <= '0;
      idx_q    <= '0;
      sel_q    <= '0;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      ovf_q    <= ovf_d;
      bad_q    <= bad_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign dig_sel   = sel_q;
  assign bad_digit = bad_q;
endmodule
